// File: rtl/approx_product_accumulator_if.sv
// Product-stream and sum-delivery bundle for approx_product_accumulator.
// slave: accumulator side; master: producer/consumer side.
interface approx_product_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) ();
  logic [15:0]      product_i;
  logic             valid_i;
  logic             last_i;
  logic             ready_o;
  logic             clear_i;
  logic [ACC_W-1:0] sum_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
  logic             sum_valid_o;
  logic             sum_ready_i;

  modport slave (
    input  product_i, valid_i, last_i, clear_i, sum_ready_i,
    output ready_o, sum_o, count_o, overflow_o, sum_valid_o
  );

  modport master (
    output product_i, valid_i, last_i, clear_i, sum_ready_i,
    input  ready_o, sum_o, count_o, overflow_o, sum_valid_o
  );
endinterface

// File: rtl/approx_product_accumulator.sv
// Dot-product accumulator for approximate multiplier products.
// ACC_SATURATE_EN: clamp the sum to all-ones on overflow instead of wrapping.
module approx_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic clk_i,
  input logic rst_i,
  approx_product_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [ACC_W-1:0] sum_q, sum_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             ovfo_q, ovfo_n;

  logic [ACC_W:0]   add;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;
  logic             carry;
  logic             accept;

  assign add = {1'b0, acc}
             + {{(ACC_W-15){1'b0}}, bus.product_i};
  assign carry = add[ACC_W];

`ifdef ACC_SATURATE_EN
  // once clamped, any further add either carries again or adds zero
  assign acc_add = carry ? '1 : add[ACC_W-1:0];
`else
  assign acc_add = add[ACC_W-1:0];
`endif

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign accept  = bus.valid_i & (state == ACCUM);

  assign bus.ready_o     = (state == ACCUM);
  assign bus.sum_valid_o = (state == HOLD);
  assign bus.sum_o       = sum_q;
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = ovfo_q;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    sum_n   = sum_q;
    count_n = count_q;
    ovfo_n  = ovfo_q;
    unique case (state)
      ACCUM: begin
        if (bus.clear_i) begin
          acc_n = '0;
          cnt_n = '0;
          ovf_n = 1'b0;
        end else if (accept && bus.last_i) begin
          sum_n   = acc_add;
          count_n = cnt_inc;
          ovfo_n  = ovf | carry;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          state_n = HOLD;
        end else if (accept) begin
          acc_n = acc_add;
          cnt_n = cnt_inc;
          ovf_n = ovf | carry;
        end
      end
      HOLD: begin
        if (bus.sum_ready_i) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      sum_q   <= sum_n;
      count_q <= count_n;
      ovfo_q  <= ovfo_n;
    end
  end

endmodule
